// File: rtl/bola_render.sv
// rtl/bola_render.sv - bouncing square ball pixel generator behind the VGA timing counters
// Registered RGB with one cycle of latency; the ball moves once per frame during blanking.
module bola_render #(
  parameter int          BALL_SIZE = 16,
  parameter int          SPEED     = 2,
  parameter int          INIT_X    = 312,
  parameter int          INIT_Y    = 232,
  parameter logic [23:0] BALL_RGB  = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB    = 24'h000080
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       ativo,
  input  logic       enable,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic [9:0] pos_x,
  output logic [8:0] pos_y,
  output logic       frame_tick
);

  typedef enum logic {SYNC, RUN} state_t;

  localparam logic [10:0] SIZE11  = 11'(BALL_SIZE);
  localparam logic [10:0] SPEED11 = 11'(SPEED);
  localparam logic [10:0] MAX_X11 = 11'(640 - BALL_SIZE);
  localparam logic [10:0] MAX_Y11 = 11'(480 - BALL_SIZE);

  state_t      state_q;
  logic [23:0] rgb_q;
  logic [9:0]  pos_x_q, pos_x_d;
  logic [8:0]  pos_y_q, pos_y_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;
  logic        tick_q;

  logic        in_range, act, hit, slot, frame_start;
  logic [9:0]  sx, sy;
  logic [10:0] px11, py11, sx11, sy11;

  // Out-of-range counters never light a pixel and never count as an update slot.
  assign in_range    = (x < 10'd800) && (y < 10'd525);
  assign act         = ativo && in_range;
  assign slot        = (x == 10'd0) && (y == 10'd515);
  assign frame_start = (x == 10'd0) && (y == 10'd0);

  assign sx   = x - 10'd144;
  assign sy   = y - 10'd35;
  assign sx11 = {1'b0, sx};
  assign sy11 = {1'b0, sy};
  assign px11 = {1'b0, pos_x_q};
  assign py11 = {2'b00, pos_y_q};

  assign hit = (sx11 >= px11) && (sx11 < px11 + SIZE11) &&
               (sy11 >= py11) && (sy11 < py11 + SIZE11);

  always_comb begin
    pos_x_d = pos_x_q;
    dir_x_d = dir_x_q;
    pos_y_d = pos_y_q;
    dir_y_d = dir_y_q;
    if (dir_x_q) begin
      if (px11 + SPEED11 >= MAX_X11) begin
        pos_x_d = 10'(MAX_X11);
        dir_x_d = 1'b0;
      end else begin
        pos_x_d = 10'(px11 + SPEED11);
      end
    end else if (px11 <= SPEED11) begin
      pos_x_d = 10'd0;
      dir_x_d = 1'b1;
    end else begin
      pos_x_d = 10'(px11 - SPEED11);
    end
    if (dir_y_q) begin
      if (py11 + SPEED11 >= MAX_Y11) begin
        pos_y_d = 9'(MAX_Y11);
        dir_y_d = 1'b0;
      end else begin
        pos_y_d = 9'(py11 + SPEED11);
      end
    end else if (py11 <= SPEED11) begin
      pos_y_d = 9'd0;
      dir_y_d = 1'b1;
    end else begin
      pos_y_d = 9'(py11 - SPEED11);
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (!reset) begin
      state_q <= SYNC;
      rgb_q   <= 24'h0;
      pos_x_q <= 10'(INIT_X);
      pos_y_q <= 9'(INIT_Y);
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      case (state_q)
        SYNC: begin
          rgb_q  <= 24'h0;
          tick_q <= 1'b0;
          if (frame_start) state_q <= RUN;
        end
        default: begin
          rgb_q  <= act ? (hit ? BALL_RGB : BG_RGB) : 24'h0;
          tick_q <= slot;
          if (slot && enable) begin
            pos_x_q <= pos_x_d;
            dir_x_q <= dir_x_d;
            pos_y_q <= pos_y_d;
            dir_y_q <= dir_y_d;
          end
        end
      endcase
    end
  end

  assign VGA_R      = rgb_q[23:16];
  assign VGA_G      = rgb_q[15:8];
  assign VGA_B      = rgb_q[7:0];
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign frame_tick = tick_q;

endmodule

// File: doc/bola_render.md
# bola_render

Pixel-generation stage directly downstream of the VGA timing generator. Consumes the raster counters `x`, `y` and the `ativo` flag on the pixel clock, moves a square ball once per frame with edge bouncing, and drives registered 8-bit RGB for the DAC. Outside the active window the output is forced black.

## Interface
Parameters:
- `BALL_SIZE`, 16: ball side in pixels (2..64)
- `SPEED`, 2: pixels moved per frame on each axis (1..15)
- `INIT_X`, 312: ball left edge after reset, screen coordinates
- `INIT_Y`, 232: ball top edge after reset, screen coordinates
- `BALL_RGB`, 24'hFFFFFF: ball colour {R,G,B}
- `BG_RGB`, 24'h000080: background colour {R,G,B}

Ports:
- `VGA_CLK` input 1: pixel clock, same clock that advances `x`/`y`
- `reset` input 1: synchronous, active-low (0 = reset), sampled on `VGA_CLK` rising edge
- `x` input 10: horizontal raster counter, 0..799; active columns 144..783
- `y` input 10: vertical raster counter, 0..524; active lines 35..514
- `ativo` input 1: 1 inside the active window
- `enable` input 1: 1 = ball moves at frame updates; 0 = ball frozen
- `VGA_R`, `VGA_G`, `VGA_B` output 8 each: registered pixel colour
- `pos_x` output 10: ball left edge, screen coordinates 0..640-BALL_SIZE
- `pos_y` output 9: ball top edge, screen coordinates 0..480-BALL_SIZE
- `frame_tick` output 1: one-cycle pulse on each position-update slot

## Operation
- Screen coordinates: `sx = x - 144`, `sy = y - 35`, 10-bit subtraction; only meaningful when `ativo` = 1.
- FSM, two states:
  - SYNC: entered on reset. RGB forced to 0. Leaves to RUN on the first cycle with `x` = 0 and `y` = 0.
  - RUN: normal drawing and movement. Only reset returns to SYNC.
- Pixel select in RUN: ball hit when `pos_x <= sx < pos_x+BALL_SIZE` and `pos_y <= sy < pos_y+BALL_SIZE`.
  - `ativo` = 1 and hit: BALL_RGB.
  - `ativo` = 1, no hit: BG_RGB.
  - `ativo` = 0: 0.
- Update slot: the cycle in RUN where `x` = 0 and `y` = 515 (first blanking line). `frame_tick` = 1 in the following cycle, whatever `enable` is.
- Movement at the update slot when `enable` = 1, using direction flags `dir_x`/`dir_y` (1 = +, 0 = −):
  - Moving +X: if `pos_x + SPEED >= 640-BALL_SIZE`, then `pos_x <= 640-BALL_SIZE` and `dir_x <= 0`; else `pos_x <= pos_x + SPEED`.
  - Moving −X: if `pos_x <= SPEED`, then `pos_x <= 0` and `dir_x <= 1`; else `pos_x <= pos_x - SPEED`.
  - Y follows the same rules with limit `480-BALL_SIZE`.
  - Both axes update in the same cycle and independently; corner hits flip both flags.
  - Comparisons use 11-bit intermediates; no wrap-around is possible.
- `enable` = 0 at the update slot: position and direction are held, and `frame_tick` still pulses.
- Position changes only during blanking, so no tearing within a frame.

## Timing
- Reset values (the cycle after `reset` is sampled 0):
  - `VGA_R`/`VGA_G`/`VGA_B` = 0
  - `pos_x` = INIT_X, `pos_y` = INIT_Y
  - `dir_x` = `dir_y` = 1
  - `frame_tick` = 0
  - state = SYNC
- Reset mid-frame: takes effect at the next edge. The block returns to SYNC, outputs black until the next `x`=0/`y`=0, and drops any pending update.
- RGB latency is 1 cycle: the colour for (`x`,`y`,`ativo`) sampled at edge N appears after edge N. The downstream register stage compensates for the 1-pixel offset against HS/VS.
- `pos_x`/`pos_y` change one cycle after the update slot and are stable for the rest of the frame.
- `frame_tick` is high for exactly one `VGA_CLK` cycle per 800×525 frame, and never while in SYNC.
- Out-of-range inputs (`x` ≥ 800, `y` ≥ 525) do not corrupt state: they are treated as `ativo` = 0 and as non-update cycles.

## Test plan
- Reset then first frame: hold `reset`=0 for 4 cycles, release at `x`=400, `y`=100 -> RGB = 0 until `x`=0/`y`=0, then (`x`=144, `y`=35) gives 24'h000080 one cycle later.
- Ball pixel hit at defaults: (`x`=144+312, `y`=35+232) -> RGB = FFFFFF next cycle. (`x`=144+328, same `y`) -> 000080. (`x`=144+311) -> 000080.
- Movement: `enable`=1, run 3 frames from reset -> `pos_x`=318, `pos_y`=238, three `frame_tick` pulses, each one cycle after `x`=0/`y`=515.
- Right-wall bounce: INIT_X=620, SPEED=2, BALL_SIZE=16 -> frame 1: `pos_x`=622 then 624; next frame `dir_x`=0, `pos_x` 624→622.
- Corner bounce with `enable` toggling: INIT_X=1, INIT_Y=1, directions forced − via a bounce sequence -> both clamp to 0, both flags flip in the same slot. With `enable`=0 for one frame, position is unchanged but `frame_tick` still pulses.
- Mid-frame reset: assert `reset`=0 for 1 cycle at `x`=500, `y`=300 -> next cycle RGB = 0, `pos` back to INIT, black until the next `x`=0/`y`=0.
